instruction_fetch_bus: RTL and testbench
========================================

# instruction_fetch_bus

Bus-side fetch engine that sits between the IF-stage PC register and the external instruction memory bus. It takes the current fetch PC and runs a request/acknowledge read transaction on the instruction bus. It returns the fetched word to the IF/ID pipeline register and holds the PC via a stall request until the word is available. It also handles pipeline flushes with a fetch in flight, misaligned PCs and unresponsive memory.

## Interface
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without bus_acknowledge before the fetch is aborted (range 1..255).
- clock  input  1  single design clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc  input  32  current fetch address from the IF-stage PC register.
- stall  input  6  pipeline stall vector; stall[0]=1 freezes IF.
- flush  input  1  pipeline flush (taken branch/exception); the current fetch result must never reach ID.
- stall_request  output  1  asks the stall controller to freeze IF (PC must not advance).
- instruction  output  32  fetched instruction word to the IF/ID register.
- instruction_valid  output  1  instruction holds a completed fetch for the current pc.
- address_error  output  1  current fetch was rejected for pc[1:0] != 0.
- bus_timeout  output  1  current fetch was aborted after TIMEOUT_CYCLES.
- bus_request  output  1  read request to instruction memory.
- bus_address  output  32  read address, stable while bus_request=1.
- bus_acknowledge  input  1  memory completes the read this cycle.
- bus_read_data  input  32  read data, valid when bus_acknowledge=1.

## Operation
- States: IDLE, WAIT, DONE, DISCARD.
- stall_request = 1 in IDLE, WAIT and DISCARD; 0 in DONE. It is a Moore output, decoded from state only.
- instruction_valid = 1 only in DONE.
- IDLE, flush=0, pc[1:0]=0:
  - bus_request<=1, bus_address<=pc, timeout counter<=0.
  - Go to WAIT.
- IDLE, flush=0, pc[1:0]!=0:
  - No bus access.
  - instruction<=0, address_error<=1.
  - Go to DONE.
- IDLE, flush=1: stay in IDLE; no request is issued that cycle.
- WAIT, bus_acknowledge=1, flush=0:
  - instruction<=bus_read_data, bus_request<=0.
  - Go to DONE.
- WAIT, bus_acknowledge=1, flush=1:
  - Data is dropped, instruction<=0, bus_request<=0.
  - Go to IDLE.
- WAIT, bus_acknowledge=0, flush=1:
  - Go to DISCARD.
  - bus_request and bus_address stay unchanged; a started bus transaction is never withdrawn.
- WAIT, no acknowledge, counter reaches TIMEOUT_CYCLES-1:
  - bus_request<=0, instruction<=0, bus_timeout<=1.
  - Go to DONE.
  - If flush is also asserted, go to IDLE instead, with no bus_timeout.
  - Otherwise the counter increments by 1 per WAIT cycle. It is 8 bits wide and saturates; it never wraps.
- DISCARD:
  - On bus_acknowledge or timeout: bus_request<=0, data dropped, go to IDLE.
  - flush is ignored (already discarding).
- DONE, flush=1: go to IDLE; instruction_valid drops next cycle.
- DONE, stall[0]=1 and flush=0: hold DONE with all outputs unchanged, even for many cycles.
- DONE, stall[0]=0 and flush=0: go to IDLE. The PC advances on this same edge.
- address_error and bus_timeout clear on every exit from DONE.
- bus_address updates only on IDLE->WAIT.

## Timing
- Reset (async assert): state=IDLE; stall_request=1; all other outputs 0 (instruction, bus_address, bus_request, instruction_valid, address_error, bus_timeout).
- A reset asserted mid-WAIT drops bus_request immediately, without waiting for a clock edge.
- Zero-wait memory (ack in first WAIT cycle):
  - Edge 0: IDLE samples pc.
  - Cycle 1: WAIT, bus_request=1.
  - Cycle 2: DONE, instruction valid.
  - Throughput is one instruction per 3 cycles.
- Each additional wait state adds exactly one cycle.
- Misaligned pc: DONE with address_error one cycle after IDLE; 2 cycles per fault.
- Timeout: bus_request is high for exactly TIMEOUT_CYCLES cycles, then DONE with bus_timeout=1.
- bus_acknowledge is ignored in IDLE and DONE.

## Test plan
- Zero-wait fetch:
  - Stimulus: pc=0x00000010; memory acks in the first WAIT cycle with 0x3C011234.
  - Required: bus_address=0x10 for 1 cycle; instruction=0x3C011234 with instruction_valid=1 in cycle 2; stall_request 1,1,0.
- Wait states:
  - Stimulus: ack 3 cycles after request; stall[0]=1 for 2 cycles in DONE.
  - Required: bus_request high 4 cycles, bus_address stable; DONE held 3 cycles with instruction unchanged.
- Flush in WAIT:
  - Stimulus: flush pulse 1 cycle after request, ack 2 cycles later with 0xDEADBEEF.
  - Required: DISCARD entered; instruction_valid never 1; instruction=0; a new fetch of the new pc follows.
- Misaligned pc:
  - Stimulus: pc=0x00000006.
  - Required: bus_request stays 0; address_error=1, instruction=0, instruction_valid=1 one cycle after IDLE.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, no ack.
  - Required: bus_request high exactly 4 cycles; then bus_timeout=1, instruction=0 in DONE; a late ack after that is ignored.
- Reset mid-WAIT:
  - Stimulus: assert reset between edges while bus_request=1.
  - Required: bus_request=0 before the next edge; all other outputs at reset values; stall_request=1.

Source files
------------

// File: rtl/instruction_fetch_bus.sv
// Bus-side instruction fetch engine: runs one request/acknowledge read per PC,
// holds IF through stall_request, and handles flush, misaligned PCs and bus timeouts.
module instruction_fetch_bus #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        stall_request,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  output logic        address_error,
  output logic        bus_timeout,
  output logic        bus_request,
  output logic [31:0] bus_address,
  input  logic        bus_acknowledge,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DISCARD} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] instruction_reg, instruction_next;
  logic [31:0] bus_address_reg, bus_address_next;
  logic        bus_request_reg, bus_request_next;
  logic        address_error_reg, address_error_next;
  logic        bus_timeout_reg, bus_timeout_next;
  logic [7:0]  count_reg, count_next;

  logic        timeout_hit;
  logic [7:0]  count_inc;
  logic        aligned;
  logic        unused_stall;

  assign timeout_hit  = (count_reg == LAST_COUNT);
  assign count_inc    = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
  assign aligned      = (pc[1:0] == 2'b00);
  assign unused_stall = ^stall[5:1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!flush) begin
          state_next = aligned ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (bus_acknowledge) begin
          state_next = flush ? IDLE : DONE;
        end else if (timeout_hit) begin
          state_next = flush ? IDLE : DONE;
        end else if (flush) begin
          state_next = DISCARD;
        end
      end
      DONE: begin
        if (flush || !stall[0]) begin
          state_next = IDLE;
        end
      end
      DISCARD: begin
        if (bus_acknowledge || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore decode: IF is frozen everywhere except while a result is presented
  always_comb begin
    stall_request     = (state_reg != DONE);
    instruction_valid = (state_reg == DONE);
  end

  always_comb begin
    instruction_next   = instruction_reg;
    bus_address_next   = bus_address_reg;
    bus_request_next   = bus_request_reg;
    address_error_next = address_error_reg;
    bus_timeout_next   = bus_timeout_reg;
    count_next         = count_reg;
    case (state_reg)
      IDLE: begin
        if (!flush) begin
          if (aligned) begin
            bus_request_next = 1'b1;
            bus_address_next = pc;
            count_next       = 8'd0;
          end else begin
            instruction_next   = 32'd0;
            address_error_next = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus_acknowledge) begin
          bus_request_next = 1'b0;
          instruction_next = flush ? 32'd0 : bus_read_data;
        end else if (timeout_hit) begin
          bus_request_next = 1'b0;
          instruction_next = 32'd0;
          bus_timeout_next = !flush;
        end else begin
          // flush without ack keeps the request up; the transaction must finish
          count_next = count_inc;
        end
      end
      DONE: begin
        if (flush || !stall[0]) begin
          address_error_next = 1'b0;
          bus_timeout_next   = 1'b0;
        end
      end
      DISCARD: begin
        if (bus_acknowledge || timeout_hit) begin
          bus_request_next = 1'b0;
          instruction_next = 32'd0;
        end else begin
          count_next = count_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction_reg   <= 32'd0;
      bus_address_reg   <= 32'd0;
      bus_request_reg   <= 1'b0;
      address_error_reg <= 1'b0;
      bus_timeout_reg   <= 1'b0;
      count_reg         <= 8'd0;
    end else begin
      instruction_reg   <= instruction_next;
      bus_address_reg   <= bus_address_next;
      bus_request_reg   <= bus_request_next;
      address_error_reg <= address_error_next;
      bus_timeout_reg   <= bus_timeout_next;
      count_reg         <= count_next;
    end
  end

  assign instruction   = instruction_reg;
  assign bus_address   = bus_address_reg;
  assign bus_request   = bus_request_reg;
  assign address_error = address_error_reg;
  assign bus_timeout   = bus_timeout_reg;

endmodule

// File: tb/tb_instruction_fetch_bus.sv
// Directed bench for instruction_fetch_bus: stimulus pushes expected fetch results,
// a monitor pops and compares on every new instruction_valid.
module tb_instruction_fetch_bus;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic        flush;
  logic        stall_request;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        address_error;
  logic        bus_timeout;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_acknowledge;
  logic [31:0] bus_read_data;

  typedef struct packed {
    logic [31:0] instr;
    logic        aerr;
    logic        tout;
  } result_t;

  result_t exp_q[$];
  int      errors = 0;
  int      checks = 0;
  bit      stim_done = 0;

  instruction_fetch_bus #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .pc               (pc),
    .stall            (stall),
    .flush            (flush),
    .stall_request    (stall_request),
    .instruction      (instruction),
    .instruction_valid(instruction_valid),
    .address_error    (address_error),
    .bus_timeout      (bus_timeout),
    .bus_request      (bus_request),
    .bus_address      (bus_address),
    .bus_acknowledge  (bus_acknowledge),
    .bus_read_data    (bus_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: one pop per fetch result, on the first cycle of DONE
  initial begin
    logic prev_valid;
    result_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && instruction_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", instruction, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          chk("mon_instruction", instruction, e.instr);
          chk("mon_address_error", {31'd0, address_error}, {31'd0, e.aerr});
          chk("mon_bus_timeout", {31'd0, bus_timeout}, {31'd0, e.tout});
        end
      end
      prev_valid = reset ? 1'b0 : instruction_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pc = 32'd0;
    stall = 6'd0;
    flush = 1'b1;
    bus_acknowledge = 1'b0;
    bus_read_data = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_stall_request", {31'd0, stall_request}, 32'd1);
    chk("rst_bus_request", {31'd0, bus_request}, 32'd0);
    chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_bus_address", bus_address, 32'd0);
    reset = 1'b0;
    tick();
    chk("park_idle_no_request", {31'd0, bus_request}, 32'd0);

    // Zero-wait fetch
    pc = 32'h10; flush = 1'b0;
    tick();
    chk("zw_bus_request", {31'd0, bus_request}, 32'd1);
    chk("zw_bus_address", bus_address, 32'h10);
    chk("zw_stall_c1", {31'd0, stall_request}, 32'd1);
    bus_acknowledge = 1'b1; bus_read_data = 32'h3C011234;
    exp_q.push_back('{32'h3C011234, 1'b0, 1'b0});
    tick();
    chk("zw_valid", {31'd0, instruction_valid}, 32'd1);
    chk("zw_stall_c2", {31'd0, stall_request}, 32'd0);
    chk("zw_bus_request_drop", {31'd0, bus_request}, 32'd0);
    bus_acknowledge = 1'b0; flush = 1'b1;
    tick();
    chk("zw_valid_after_flush", {31'd0, instruction_valid}, 32'd0);

    // Wait states plus stall hold in DONE
    pc = 32'h20; flush = 1'b0;
    exp_q.push_back('{32'h11223344, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ws_bus_request", {31'd0, bus_request}, 32'd1);
      chk("ws_bus_address", bus_address, 32'h20);
      if (i == 3) begin
        bus_acknowledge = 1'b1; bus_read_data = 32'h11223344;
      end
    end
    tick();
    bus_acknowledge = 1'b0; bus_read_data = 32'hFFFFFFFF; stall = 6'd1;
    chk("ws_done_c1", {31'd0, instruction_valid}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ws_done_hold_valid", {31'd0, instruction_valid}, 32'd1);
      chk("ws_done_hold_instr", instruction, 32'h11223344);
    end
    stall = 6'd0;
    tick();
    flush = 1'b1;
    chk("ws_left_done", {31'd0, instruction_valid}, 32'd0);

    // Flush while waiting: result is discarded, then the new pc is fetched
    pc = 32'h30; flush = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; pc = 32'h40;
    chk("fl_request_held", {31'd0, bus_request}, 32'd1);
    chk("fl_no_valid_a", {31'd0, instruction_valid}, 32'd0);
    tick();
    chk("fl_no_valid_b", {31'd0, instruction_valid}, 32'd0);
    chk("fl_stall_request", {31'd0, stall_request}, 32'd1);
    bus_acknowledge = 1'b1; bus_read_data = 32'hDEADBEEF;
    tick();
    bus_acknowledge = 1'b0;
    chk("fl_idle_no_request", {31'd0, bus_request}, 32'd0);
    chk("fl_instruction_zero", instruction, 32'd0);
    chk("fl_no_valid_c", {31'd0, instruction_valid}, 32'd0);
    tick();
    chk("fl_new_address", bus_address, 32'h40);
    chk("fl_new_request", {31'd0, bus_request}, 32'd1);
    bus_acknowledge = 1'b1; bus_read_data = 32'h55AA55AA;
    exp_q.push_back('{32'h55AA55AA, 1'b0, 1'b0});
    tick();
    bus_acknowledge = 1'b0; flush = 1'b1;
    tick();

    // Misaligned pc
    pc = 32'h06; flush = 1'b0;
    exp_q.push_back('{32'h0, 1'b1, 1'b0});
    tick();
    flush = 1'b1;
    chk("ma_no_request", {31'd0, bus_request}, 32'd0);
    chk("ma_address_error", {31'd0, address_error}, 32'd1);
    chk("ma_valid", {31'd0, instruction_valid}, 32'd1);
    tick();
    chk("ma_error_cleared", {31'd0, address_error}, 32'd0);

    // Timeout with TIMEOUT_CYCLES=4, then a late ack that must be ignored
    pc = 32'h50; flush = 1'b0;
    exp_q.push_back('{32'h0, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_bus_request", {31'd0, bus_request}, 32'd1);
    end
    tick();
    chk("to_request_dropped", {31'd0, bus_request}, 32'd0);
    chk("to_bus_timeout", {31'd0, bus_timeout}, 32'd1);
    chk("to_instruction", instruction, 32'd0);
    bus_acknowledge = 1'b1; bus_read_data = 32'h99999999; stall = 6'd1;
    tick();
    chk("to_late_ack_instr", instruction, 32'd0);
    chk("to_late_ack_valid", {31'd0, instruction_valid}, 32'd1);
    bus_acknowledge = 1'b0; stall = 6'd0; flush = 1'b1;
    tick();
    chk("to_timeout_cleared", {31'd0, bus_timeout}, 32'd0);

    // Asynchronous reset in the middle of a WAIT cycle
    pc = 32'h60; flush = 1'b0;
    tick();
    chk("rw_request_up", {31'd0, bus_request}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rw_request_async_drop", {31'd0, bus_request}, 32'd0);
    chk("rw_stall_request", {31'd0, stall_request}, 32'd1);
    chk("rw_bus_address", bus_address, 32'd0);
    chk("rw_instruction", instruction, 32'd0);
    tick();
    reset = 1'b0; flush = 1'b1;
    tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    stim_done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
